// File: rtl/serial_adder_ctrl_if.sv
// Handshake and data bundle for the bit-serial adder: operand request
// channel (start_*, a/b/cin) and result channel (res_*, sum/cout).
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
) ();

  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin_in;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] sum_out;
  logic             cout_out;
  logic             busy;

  // Requester side: presents operands and consumes results.
  modport master (
    output start_valid, a_in, b_in, cin_in, res_ready,
    input  start_ready, res_valid, sum_out, cout_out, busy
  );

  // Adder side.
  modport slave (
    input  start_valid, a_in, b_in, cin_in, res_ready,
    output start_ready, res_valid, sum_out, cout_out, busy
  );

endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: operands are accepted in parallel, added LSB-first
// through a single full-adder cell one bit per clock with the carry kept
// in a flop, and the collected sum is returned over a valid/ready channel.

// One-bit full-adder cell shared by every bit position.
module fadder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_adder_ctrl_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q,     state_d;
  logic [WIDTH-1:0] a_q,         a_d;
  logic [WIDTH-1:0] b_q,         b_d;
  logic [WIDTH-1:0] s_q,         s_d;
  logic             carry_q,     carry_d;
  logic [CW-1:0]    cnt_q,       cnt_d;
  logic [WIDTH-1:0] sum_q,       sum_d;
  logic             cout_q,      cout_d;
  logic             res_valid_q, res_valid_d;
  logic             busy_q,      busy_d;

  logic fa_s;
  logic fa_co;

  // The current LSBs of the operand shifters and the stored carry feed the cell.
  fadder u_fadder (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // Next-state logic: load on accept, shift one bit per RUN cycle, hold the
  // result in DONE until the consumer takes it.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    s_d         = s_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    res_valid_d = res_valid_q;
    busy_d      = busy_q;

    case (state_q)
      IDLE: begin
        if (bus.start_valid) begin
          a_d     = bus.a_in;
          b_d     = bus.b_in;
          carry_d = bus.cin_in;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end

      RUN: begin
        s_d     = {fa_s, s_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_co;
        if (cnt_q == CNT_LAST) begin
          // Last bit: publish the result; the counter holds rather than wrap.
          sum_d       = {fa_s, s_q[WIDTH-1:1]};
          cout_d      = fa_co;
          res_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DONE: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        res_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      s_q         <= s_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.start_ready = (state_q == IDLE);
  assign bus.res_valid   = res_valid_q;
  assign bus.sum_out     = sum_q;
  assign bus.cout_out    = cout_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed corner cases, random
// operands against an arithmetic reference, stalls, reset abort and
// back-to-back operation.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: plain (WIDTH+1)-bit addition.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic c);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  // Runs one operation from IDLE; returns the result and the accept-to-valid latency.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        output logic [W-1:0] sum, output logic cout, output int lat);
    bit got;
    bus.a_in        = a;
    bus.b_in        = b;
    bus.cin_in      = c;
    bus.start_valid = 1'b1;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (bus.res_valid) got = 1'b1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("[TB] FAIL run_op_timeout: res_valid never rose (a=%h b=%h cin=%0d)", a, b, c);
    end
    sum  = bus.sum_out;
    cout = bus.cout_out;
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
  endtask

  // Reset state of all outputs.
  task automatic test_reset();
    rst_n           = 1'b0;
    bus.start_valid = 1'b0;
    bus.res_ready   = 1'b0;
    bus.a_in        = '0;
    bus.b_in        = '0;
    bus.cin_in      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.start_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL reset_start_ready: got %b want 1", bus.start_ready);
    end
    checks++;
    if (bus.res_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_res_valid: got %b want 0", bus.res_valid);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy);
    end
    checks++;
    if ({bus.cout_out, bus.sum_out} !== 9'h000) begin
      failures++; $display("[TB] FAIL reset_result: got %h want 000", {bus.cout_out, bus.sum_out});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Directed corner cases, including a full carry ripple, and the latency.
  task automatic test_directed();
    logic [W-1:0] ta [3];
    logic [W-1:0] tb [3];
    logic         tc [3];
    logic [W:0]   te [3];
    logic [W-1:0] sum;
    logic         cout;
    int           lat;
    ta = '{8'h35, 8'hFF, 8'hFF};
    tb = '{8'h4A, 8'h01, 8'hFF};
    tc = '{1'b0, 1'b0, 1'b1};
    te = '{9'h07F, 9'h100, 9'h1FF};
    for (int i = 0; i < 3; i++) begin
      run_op(ta[i], tb[i], tc[i], sum, cout, lat);
      checks++;
      if ({cout, sum} !== te[i]) begin
        failures++;
        $display("[TB] FAIL directed_%0d: got %h want %h", i, {cout, sum}, te[i]);
      end
      checks++;
      if (lat != W) begin
        failures++;
        $display("[TB] FAIL latency_%0d: got %0d edges want %0d", i, lat, W);
      end
    end
  endtask

  // Random operands against the arithmetic reference.
  task automatic test_random();
    logic [W-1:0] a, b, sum;
    logic         c, cout;
    int           lat;
    for (int i = 0; i < 16; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      c = 1'($urandom_range(0, 1));
      run_op(a, b, c, sum, cout, lat);
      checks++;
      if ({cout, sum} !== model(a, b, c)) begin
        failures++;
        $display("[TB] FAIL random_%0d: %h+%h+%0d got %h want %h", i, a, b, c,
                 {cout, sum}, model(a, b, c));
      end
    end
  endtask

  // Result held while the consumer stalls; a start during RUN is ignored.
  task automatic test_stall();
    logic [W:0] exp;
    int         n;
    exp = model(8'h5C, 8'h27, 1'b1);
    bus.a_in        = 8'h5C;
    bus.b_in        = 8'h27;
    bus.cin_in      = 1'b1;
    bus.start_valid = 1'b1;
    @(posedge clk); #1;
    bus.a_in   = 8'h11;
    bus.b_in   = 8'h22;
    bus.cin_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (bus.start_ready !== 1'b0 || bus.busy !== 1'b1) begin
        failures++;
        $display("[TB] FAIL stall_run_flags: start_ready=%b busy=%b want 0/1",
                 bus.start_ready, bus.busy);
      end
      @(posedge clk); #1;
    end
    bus.start_valid = 1'b0;
    n = 0;
    while (!bus.res_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.res_valid !== 1'b1 || bus.start_ready !== 1'b0 ||
          {bus.cout_out, bus.sum_out} !== exp) begin
        failures++;
        $display("[TB] FAIL stall_hold_%0d: valid=%b ready=%b result=%h want 1/0/%h", i,
                 bus.res_valid, bus.start_ready, {bus.cout_out, bus.sum_out}, exp);
      end
      @(posedge clk); #1;
    end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    checks++;
    if (bus.start_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL stall_release: ready=%b valid=%b busy=%b want 1/0/0",
               bus.start_ready, bus.res_valid, bus.busy);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0 || {bus.cout_out, bus.sum_out} !== exp) begin
      failures++;
      $display("[TB] FAIL stall_no_extra_start: busy=%b result=%h want 0/%h",
               bus.busy, {bus.cout_out, bus.sum_out}, exp);
    end
  endtask

  // Reset in the middle of RUN aborts the operation cleanly.
  task automatic test_reset_abort();
    logic [W-1:0] sum;
    logic         cout;
    int           lat;
    bus.a_in        = 8'hAA;
    bus.b_in        = 8'h55;
    bus.cin_in      = 1'b0;
    bus.start_valid = 1'b1;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0 || bus.start_ready !== 1'b1 ||
        {bus.cout_out, bus.sum_out} !== 9'h000) begin
      failures++;
      $display("[TB] FAIL abort_state: valid=%b busy=%b ready=%b result=%h want 0/0/1/000",
               bus.res_valid, bus.busy, bus.start_ready, {bus.cout_out, bus.sum_out});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.start_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abort_idle: ready=%b valid=%b want 1/0", bus.start_ready, bus.res_valid);
    end
    run_op(8'h10, 8'h20, 1'b0, sum, cout, lat);
    checks++;
    if ({cout, sum} !== 9'h030) begin
      failures++;
      $display("[TB] FAIL abort_next_op: got %h want 030", {cout, sum});
    end
  endtask

  // Continuous start_valid and res_ready: two ops accepted WIDTH+2 edges apart.
  task automatic test_back_to_back();
    logic [W-1:0] oa [2];
    logic [W-1:0] ob [2];
    logic         oc [2];
    logic [W:0]   got [2];
    int           acc_edge [2];
    int           nacc, nres, edge_no;
    bit           acc_this;
    oa = '{W'($urandom), W'($urandom)};
    ob = '{W'($urandom), W'($urandom)};
    oc = '{1'b1, 1'b0};
    nacc = 0;
    nres = 0;
    edge_no = 0;
    bus.res_ready   = 1'b1;
    bus.a_in        = oa[0];
    bus.b_in        = ob[0];
    bus.cin_in      = oc[0];
    bus.start_valid = 1'b1;
    while (nres < 2 && edge_no < 60) begin
      acc_this = bus.start_ready && bus.start_valid;
      @(posedge clk); #1;
      edge_no++;
      if (acc_this && nacc < 2) begin
        acc_edge[nacc] = edge_no;
        nacc++;
        if (nacc == 1) begin
          bus.a_in   = oa[1];
          bus.b_in   = ob[1];
          bus.cin_in = oc[1];
        end else begin
          bus.start_valid = 1'b0;
        end
      end
      if (bus.res_valid && nres < 2) begin
        got[nres] = {bus.cout_out, bus.sum_out};
        nres++;
      end
    end
    bus.start_valid = 1'b0;
    bus.res_ready   = 1'b0;
    checks++;
    if (nacc != 2 || nres != 2) begin
      failures++;
      $display("[TB] FAIL b2b_counts: accepts=%0d results=%0d want 2/2", nacc, nres);
    end else begin
      checks++;
      if (acc_edge[1] - acc_edge[0] != W + 2) begin
        failures++;
        $display("[TB] FAIL b2b_spacing: got %0d edges want %0d",
                 acc_edge[1] - acc_edge[0], W + 2);
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (got[i] !== model(oa[i], ob[i], oc[i])) begin
          failures++;
          $display("[TB] FAIL b2b_result_%0d: got %h want %h", i, got[i],
                   model(oa[i], ob[i], oc[i]));
        end
      end
    end
    @(posedge clk); #1;
  endtask

  // Test sequence.
  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_random();
    test_stall();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
